br_update_scheduler: RTL

BR_UPDATE_SCHEDULER -- requirements
Module: br_update_scheduler

---
 rtl/br_update_scheduler_pkg.sv | 27 ++
 rtl/br_update_queue.sv | 74 +++++++
 rtl/br_update_scheduler.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/br_update_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | FetchUnitTypes: shared types for the branch-predictor update path.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package FetchUnitTypes;

  localparam int DEF_LANES = 2;
  localparam int DEF_DEPTH = 4;
  localparam int DEF_IDX_W = 10;
  // Queue entries carry the widest supported index; narrower tables zero-extend.
  localparam int MAX_IDX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_INIT = 2'd1,
    ST_RUN  = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic [MAX_IDX_W-1:0] index;
    logic                 taken;
    logic [31:0]          target;
  } br_upd_entry_t;

endpackage
`default_nettype wire

// File: rtl/br_update_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | br_update_queue: circular FIFO accepting up to LANES writes per cycle.|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module br_update_queue
  import FetchUnitTypes::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int LANES = DEF_LANES
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic [LANES-1:0]             enq_i,
  input  br_upd_entry_t [LANES-1:0]    enq_entry_i,
  input  logic                         deq_i,
  output br_upd_entry_t                head_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH):0]       free_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  br_upd_entry_t                 mem_q [DEPTH];
  logic [PTR_W-1:0]              head_q;
  logic [PTR_W-1:0]              tail_q;
  logic [CNT_W-1:0]              count_q;
  logic [LANES-1:0][PTR_W-1:0]   slot;
  logic [CNT_W-1:0]              enq_cnt;

  // Accepted lanes land in consecutive slots starting at the tail.
  always_comb begin
    enq_cnt = '0;
    slot    = '0;
    for (int l = 0; l < LANES; l++) begin
      slot[l] = tail_q + enq_cnt[PTR_W-1:0];
      if (enq_i[l]) begin
        enq_cnt = enq_cnt + CNT_W'(1);
      end
    end
  end

  assign head_o  = mem_q[head_q];
  assign empty_o = (count_q == '0);
  assign free_o  = CNT_W'(DEPTH) - count_q + CNT_W'(deq_i);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_q + PTR_W'(deq_i);
      tail_q  <= tail_q + enq_cnt[PTR_W-1:0];
      count_q <= count_q + enq_cnt - CNT_W'(deq_i);
    end
  end

  always_ff @(posedge clk) begin
    for (int l = 0; l < LANES; l++) begin
      if (enq_i[l]) begin
        mem_q[slot[l]] <= enq_entry_i[l];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/br_update_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | br_update_scheduler: serialises branch results into predictor writes, |
// | with a table-clearing sweep after reset or on rstStart. Revision: 1.0 |
// +----------------------------------------------------------------------+
module br_update_scheduler
  import FetchUnitTypes::*;
#(
  parameter int LANES = DEF_LANES,
  parameter int DEPTH = DEF_DEPTH,
  parameter int IDX_W = DEF_IDX_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         rstStart,
  input  logic [LANES-1:0]             brValid,
  input  logic [LANES-1:0][IDX_W-1:0]  brIndex,
  input  logic [LANES-1:0]             brTaken,
  input  logic [LANES-1:0][31:0]       brTarget,
  output logic                         updValid,
  input  logic                         updReady,
  output logic [IDX_W-1:0]             updIndex,
  output logic                         updTaken,
  output logic [31:0]                  updTarget,
  output logic                         updInit,
  output logic                         busy,
  output logic [7:0]                   dropCount
);

  localparam int CNT_W  = $clog2(DEPTH) + 1;
  localparam int DROP_W = $clog2(LANES + 1);
  localparam logic [IDX_W-1:0] SWEEP_LAST = '1;

  sched_state_e                 state_q;
  logic [IDX_W-1:0]             sweep_q;
  logic [7:0]                   drop_q;
  logic                         flush;
  logic                         deq;
  logic                         q_empty;
  logic [CNT_W-1:0]             q_free;
  br_upd_entry_t                q_head;
  br_upd_entry_t [LANES-1:0]    lane_entry;
  logic [LANES-1:0]             accept;
  logic [DROP_W-1:0]            drops;
  logic [CNT_W-1:0]             rank;
  logic [8:0]                   drop_sum;

  assign flush = (state_q == ST_IDLE) || ((state_q == ST_RUN) && rstStart);
  assign deq   = (state_q == ST_RUN) && !q_empty && updReady;

  always_comb begin
    lane_entry = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_entry[l].index  = MAX_IDX_W'(brIndex[l]);
      lane_entry[l].taken  = brTaken[l];
      lane_entry[l].target = brTarget[l];
    end
  end

  // Lower lanes claim free slots first; anything left over is a drop.
  always_comb begin
    accept = '0;
    drops  = '0;
    rank   = '0;
    for (int l = 0; l < LANES; l++) begin
      if (brValid[l]) begin
        if ((state_q == ST_RUN) && !flush && (rank < q_free)) begin
          accept[l] = 1'b1;
          rank      = rank + CNT_W'(1);
        end else begin
          drops = drops + DROP_W'(1);
        end
      end
    end
  end

  assign drop_sum = {1'b0, drop_q} + 9'(drops);

  br_update_queue #(
    .DEPTH (DEPTH),
    .LANES (LANES)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush),
    .enq_i       (accept),
    .enq_entry_i (lane_entry),
    .deq_i       (deq),
    .head_o      (q_head),
    .empty_o     (q_empty),
    .free_o      (q_free)
  );

  generate
    if (IDX_W < MAX_IDX_W) begin : g_idx_pad
      logic idx_pad_unused;
      assign idx_pad_unused = ^q_head.index[MAX_IDX_W-1:IDX_W];
    end
  endgenerate

  always_comb begin
    updValid  = 1'b0;
    updInit   = 1'b0;
    updIndex  = '0;
    updTaken  = 1'b0;
    updTarget = '0;
    case (state_q)
      ST_INIT: begin
        updValid = 1'b1;
        updInit  = 1'b1;
        updIndex = sweep_q;
      end
      ST_RUN: begin
        if (!q_empty) begin
          updValid  = 1'b1;
          updIndex  = q_head.index[IDX_W-1:0];
          updTaken  = q_head.taken;
          updTarget = q_head.target;
        end
      end
      default: ;
    endcase
  end

  assign busy      = (state_q == ST_INIT);
  assign dropCount = drop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      sweep_q <= '0;
      drop_q  <= '0;
    end else begin
      drop_q <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_INIT;
          sweep_q <= '0;
        end
        ST_INIT: begin
          if (updReady) begin
            if (sweep_q == SWEEP_LAST) begin
              state_q <= ST_RUN;
              sweep_q <= '0;
            end else begin
              sweep_q <= sweep_q + IDX_W'(1);
            end
          end
        end
        ST_RUN: begin
          if (rstStart) begin
            state_q <= ST_INIT;
            sweep_q <= '0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
